sw_array_ctrl: RTL and testbench
================================

Name: sw_array_ctrl

Overview:
- Sequencer for a linear systolic array of NUM_PE affine-gap Smith-Waterman PEs, each with a 2-bit base alphabet.
- Clears the array, then loads a query of up to NUM_PE bases into the PEs' S registers using one-hot store strobes.
- Streams the reference sequence into PE0 as T/init, drains the wavefront, and tracks the maximum alignment score from an external max-reduction tree.
- Reports the score with a one-cycle done pulse.

Parameters:
- NUM_PE, 32, number of PEs in the array (≥2).
- WIDTH, 20, score width; signed two's complement, matching the PEs.
- CNT_W, 16, width of the reference length and cycle counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  one-cycle pulse; begins a job (honoured only in IDLE)
- q_valid  in  1  query base valid
- q_ready  out  1  query base accepted when q_valid & q_ready
- q_base  in  2  query base
- q_last  in  1  marks the final query base
- r_valid  in  1  reference base valid
- r_ready  out  1  reference base accepted
- r_base  in  2  reference base
- r_last  in  1  marks the final reference base
- arr_clear  out  1  drives PE rst
- arr_s  out  2  broadcast to every PE S_in
- arr_store_s  out  NUM_PE  one-hot store_S strobes; bit i goes to PE i
- arr_t  out  2  PE0 T_in
- arr_init  out  1  PE0 init_in
- arr_pe_mask  out  NUM_PE  bit i = 1 iff i < q_len; the reduction tree ignores masked PEs
- arr_vmax  in  WIDTH  signed max of unmasked PE V outputs (combinational)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- best_score  out  WIDTH  max score of the last job
- best_cyc  out  CNT_W  sample index of the first occurrence of best_score
- ref_len  out  CNT_W  reference bases accepted in the last job
- err_q_overflow  out  1  query exceeded NUM_PE bases
- err_underrun  out  1  r_valid gap during STREAM

Behaviour:
- Reset values: every register clears; all outputs are 0 except arr_clear.
  - arr_clear = rst OR (state == CLEAR), so a mid-job reset also clears the array.
  - Reset mid-job returns the block to IDLE with no done pulse.
- IDLE:
  - start → CLEAR.
  - At the same edge, clear best_score, best_cyc, ref_len and both error flags, and set the query index qi to 0.
  - start while busy is ignored.
- CLEAR:
  - Lasts exactly one cycle with arr_clear = 1, then → LOAD_Q.
- LOAD_Q:
  - q_ready = 1.
  - On a handshake with qi < NUM_PE: arr_s = q_base and arr_store_s = (1 << qi), both combinational in the same cycle; then qi++.
  - Handshakes with qi ≥ NUM_PE drive no strobe and set err_q_overflow (sticky).
  - On a q_last handshake: q_len = min(qi + 1, NUM_PE) is registered into arr_pe_mask, then → STREAM.
  - arr_init = 0 throughout LOAD_Q.
- STREAM:
  - r_ready = 1.
  - arr_t = r_base and arr_init = r_valid, both combinational.
  - Each handshake increments ref_len; ref_len saturates at 2^CNT_W − 1.
  - r_valid = 0 after the first accepted base and before r_last sets err_underrun (sticky). The bubble still enters with init = 0 because the array cannot stall; the score is then undefined.
  - On the r_last handshake → DRAIN, with drain counter dc = 0.
- DRAIN:
  - Lasts NUM_PE + 1 cycles with arr_init = 0, arr_t = 0, r_ready = 0; then → DONE.
- Score sampling:
  - The sample counter sc starts at 0 on the cycle after the first reference handshake.
  - arr_vmax is sampled every cycle from then until the last DRAIN cycle, inclusive.
  - sc increments per sample and saturates.
  - If $signed(arr_vmax) > $signed(best_score) (strictly greater), then best_score ← arr_vmax and best_cyc ← sc.
  - best_score starts at 0, so negative samples never update it.
- DONE:
  - done = 1 for one cycle.
  - Results hold until the next start.
  - → IDLE.
- Edge cases:
  - A single-base query (q_last on the first handshake) gives q_len = 1.
  - A single-base reference goes directly to DRAIN.
  - A query handshake in CLEAR is not accepted (q_ready = 0).

Test Plan:
- Query ACGT (0,1,2,3), reference ACGT, NUM_PE = 4, MATCH = 2:
  - arr_store_s sequence must be 0001, 0010, 0100, 1000 with the matching arr_s values.
  - Mask must be 1111; best_score = 8; done fires NUM_PE + 1 cycles after the r_last handshake.
- Query of 2 bases on NUM_PE = 4: arr_pe_mask = 0011 and no store strobes on bits 2 or 3.
- Query of 6 bases on NUM_PE = 4: 4 strobes, err_q_overflow = 1, mask = 1111; the job still completes.
- Reference of 10 bases with r_valid dropped for one cycle after base 3: err_underrun = 1, ref_len = 10, done still pulses.
- arr_vmax sequence 0, 5, 3, 5, 7, 7: best_score = 7, best_cyc = 4 (first occurrence).
- rst asserted during STREAM:
  - Next cycle: busy = 0, arr_clear = 1 while rst is high, no done pulse.
  - A new start then runs a clean job with cleared error flags.

Source files
------------

// File: rtl/sw_array_ctrl_if.sv
// Bundle of the query/reference streams, systolic-array drive lines and job status
// exchanged between sw_array_ctrl (slave) and its environment (master).
interface sw_array_ctrl_if #(
    parameter int NUM_PE = 32,
    parameter int WIDTH  = 20,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              q_valid;
    logic              q_ready;
    logic [1:0]        q_base;
    logic              q_last;
    logic              r_valid;
    logic              r_ready;
    logic [1:0]        r_base;
    logic              r_last;
    logic              arr_clear;
    logic [1:0]        arr_s;
    logic [NUM_PE-1:0] arr_store_s;
    logic [1:0]        arr_t;
    logic              arr_init;
    logic [NUM_PE-1:0] arr_pe_mask;
    logic [WIDTH-1:0]  arr_vmax;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  best_score;
    logic [CNT_W-1:0]  best_cyc;
    logic [CNT_W-1:0]  ref_len;
    logic              err_q_overflow;
    logic              err_underrun;

    modport slave (
        input  start, q_valid, q_base, q_last, r_valid, r_base, r_last, arr_vmax,
        output q_ready, r_ready, arr_clear, arr_s, arr_store_s, arr_t, arr_init,
               arr_pe_mask, busy, done, best_score, best_cyc, ref_len,
               err_q_overflow, err_underrun
    );

    modport master (
        output start, q_valid, q_base, q_last, r_valid, r_base, r_last, arr_vmax,
        input  q_ready, r_ready, arr_clear, arr_s, arr_store_s, arr_t, arr_init,
               arr_pe_mask, busy, done, best_score, best_cyc, ref_len,
               err_q_overflow, err_underrun
    );
endinterface

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman systolic array: clear, load query, stream
// reference, drain the wavefront, and keep the best score seen on the max-reduction tree.
module sw_array_ctrl #(
    parameter int NUM_PE = 32,
    parameter int WIDTH  = 20,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst,
    sw_array_ctrl_if.slave ctrl_if
);
    localparam int IDX_W = $clog2(NUM_PE + 1);
    localparam logic [IDX_W-1:0] IDX_PE  = IDX_W'(NUM_PE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_Q,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  qi_q, qi_d;
    logic [IDX_W-1:0]  dc_q, dc_d;
    logic [NUM_PE-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  ref_len_q, ref_len_d;
    logic [CNT_W-1:0]  sc_q, sc_d;
    logic [CNT_W-1:0]  best_cyc_q, best_cyc_d;
    logic [WIDTH-1:0]  best_score_q, best_score_d;
    logic              sampling_q, sampling_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_und_q, err_und_d;

    logic              q_ready_c;
    logic              r_ready_c;
    logic              done_c;
    logic              init_c;
    logic [1:0]        s_c;
    logic [1:0]        t_c;
    logic [NUM_PE-1:0] store_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            qi_q         <= '0;
            dc_q         <= '0;
            mask_q       <= '0;
            ref_len_q    <= '0;
            sc_q         <= '0;
            best_cyc_q   <= '0;
            best_score_q <= '0;
            sampling_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_und_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            qi_q         <= qi_d;
            dc_q         <= dc_d;
            mask_q       <= mask_d;
            ref_len_q    <= ref_len_d;
            sc_q         <= sc_d;
            best_cyc_q   <= best_cyc_d;
            best_score_q <= best_score_d;
            sampling_q   <= sampling_d;
            err_ovf_q    <= err_ovf_d;
            err_und_q    <= err_und_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        qi_d         = qi_q;
        dc_d         = dc_q;
        mask_d       = mask_q;
        ref_len_d    = ref_len_q;
        sc_d         = sc_q;
        best_cyc_d   = best_cyc_q;
        best_score_d = best_score_q;
        sampling_d   = sampling_q;
        err_ovf_d    = err_ovf_q;
        err_und_d    = err_und_q;
        q_ready_c    = 1'b0;
        r_ready_c    = 1'b0;
        done_c       = 1'b0;
        init_c       = 1'b0;
        s_c          = '0;
        t_c          = '0;
        store_c      = '0;

        // Score window opens the cycle after the first reference base and closes with DRAIN.
        if (sampling_q && (state_q == S_STREAM || state_q == S_DRAIN)) begin
            if (sc_q != CNT_MAX) begin
                sc_d = sc_q + 1'b1;
            end
            if ($signed(ctrl_if.arr_vmax) > $signed(best_score_q)) begin
                best_score_d = ctrl_if.arr_vmax;
                best_cyc_d   = sc_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_if.start) begin
                    state_d      = S_CLEAR;
                    qi_d         = '0;
                    dc_d         = '0;
                    mask_d       = '0;
                    ref_len_d    = '0;
                    sc_d         = '0;
                    best_cyc_d   = '0;
                    best_score_d = '0;
                    sampling_d   = 1'b0;
                    err_ovf_d    = 1'b0;
                    err_und_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_LOAD_Q;
            end
            S_LOAD_Q: begin
                q_ready_c = 1'b1;
                if (ctrl_if.q_valid) begin
                    if (qi_q < IDX_PE) begin
                        s_c     = ctrl_if.q_base;
                        store_c = NUM_PE'(1) << qi_q;
                        qi_d    = qi_q + 1'b1;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                    // qi saturates at NUM_PE, so i <= qi covers q_len = min(qi + 1, NUM_PE).
                    if (ctrl_if.q_last) begin
                        for (int i = 0; i < NUM_PE; i++) begin
                            mask_d[i] = (IDX_W'(i) <= qi_q);
                        end
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                r_ready_c = 1'b1;
                t_c       = ctrl_if.r_base;
                init_c    = ctrl_if.r_valid;
                if (ctrl_if.r_valid) begin
                    if (ref_len_q != CNT_MAX) begin
                        ref_len_d = ref_len_q + 1'b1;
                    end
                    sampling_d = 1'b1;
                    if (ctrl_if.r_last) begin
                        state_d = S_DRAIN;
                        dc_d    = '0;
                    end
                end else if (sampling_q) begin
                    err_und_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (dc_q == IDX_PE) begin
                    state_d = S_DONE;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshakes and strobes are held off while reset is asserted.
        if (rst) begin
            q_ready_c = 1'b0;
            r_ready_c = 1'b0;
            done_c    = 1'b0;
            init_c    = 1'b0;
            s_c       = '0;
            t_c       = '0;
            store_c   = '0;
        end
    end

    assign ctrl_if.q_ready        = q_ready_c;
    assign ctrl_if.r_ready        = r_ready_c;
    assign ctrl_if.arr_clear      = rst | (state_q == S_CLEAR);
    assign ctrl_if.arr_s          = s_c;
    assign ctrl_if.arr_store_s    = store_c;
    assign ctrl_if.arr_t          = t_c;
    assign ctrl_if.arr_init       = init_c;
    assign ctrl_if.arr_pe_mask    = mask_q;
    assign ctrl_if.busy           = ~rst & (state_q != S_IDLE);
    assign ctrl_if.done           = done_c;
    assign ctrl_if.best_score     = best_score_q;
    assign ctrl_if.best_cyc       = best_cyc_q;
    assign ctrl_if.ref_len        = ref_len_q;
    assign ctrl_if.err_q_overflow = err_ovf_q;
    assign ctrl_if.err_underrun   = err_und_q;
endmodule

// File: tb/tb_sw_array_ctrl.sv
// Randomized scoreboard bench for sw_array_ctrl on a 4-PE array; expected strobes and
// job results come from a list-level model of each job and are checked by a monitor.
module tb_sw_array_ctrl;
    localparam int NP   = 4;
    localparam int W    = 20;
    localparam int CW   = 16;
    localparam int SENT = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sw_array_ctrl_if #(.NUM_PE(NP), .WIDTH(W), .CNT_W(CW)) bus ();

    sw_array_ctrl #(.NUM_PE(NP), .WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_if(bus)
    );

    typedef struct {
        logic [W-1:0]  best;
        logic [CW-1:0] cyc;
        logic [CW-1:0] rlen;
        logic          ovf;
        logic          und;
        logic [NP-1:0] mask;
    } res_t;

    typedef struct {
        logic [NP-1:0] st;
        logic [1:0]    s;
    } strb_t;

    res_t  expQ[$];
    strb_t strbQ[$];
    int    qB[$];
    int    rV[$];
    int    rB[$];
    int    vm[$];
    int    qn, rn, nBub, bodyLen;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rlastCyc = 0;
    int    jobsExp = 0;
    int    jobsDone = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic buildJob(input int qLen, input int rLen, input int lead, input int bubbleAfter,
                            input bit randBub, input bit negVm);
        qB.delete(); rV.delete(); rB.delete(); vm.delete();
        qn = qLen;
        rn = rLen;
        nBub = 0;
        for (int i = 0; i < qLen; i++) qB.push_back(int'($urandom_range(0, 3)));
        for (int i = 0; i < lead; i++) begin
            rV.push_back(0);
            rB.push_back(int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < rLen; i++) begin
            rV.push_back(1);
            rB.push_back(int'($urandom_range(0, 3)));
            if (i < rLen - 1 && ((i + 1 == bubbleAfter) || (randBub && $urandom_range(0, 4) == 0))) begin
                rV.push_back(0);
                rB.push_back(int'($urandom_range(0, 3)));
                nBub++;
            end
        end
        bodyLen = rLen + nBub;
        for (int k = 0; k < bodyLen + NP; k++) begin
            if (negVm) vm.push_back(-int'($urandom_range(1, 40)));
            else       vm.push_back(int'($urandom_range(0, 100)) - 40);
        end
    endtask

    // Job-level model: one strobe per stored base, best = first occurrence of max(0, samples).
    task automatic predict(input bit pushResult);
        int    loaded;
        int    mx;
        int    bc;
        strb_t sb;
        res_t  r;
        loaded = (qn < NP) ? qn : NP;
        for (int i = 0; i < loaded; i++) begin
            sb.st = NP'(1) << i;
            sb.s  = 2'(qB[i]);
            strbQ.push_back(sb);
        end
        if (pushResult) begin
            mx = 0;
            bc = 0;
            foreach (vm[k]) if (vm[k] > mx) mx = vm[k];
            if (mx > 0) begin
                for (int k = vm.size() - 1; k >= 0; k--) if (vm[k] == mx) bc = k;
            end
            r.best = W'(mx);
            r.cyc  = CW'(bc);
            r.rlen = CW'(rn);
            r.ovf  = (qn > NP);
            r.und  = (nBub > 0);
            r.mask = '0;
            for (int i = 0; i < NP; i++) r.mask[i] = (i < loaded);
            expQ.push_back(r);
            jobsExp++;
        end
    endtask

    task automatic applyStimulus(input int abortAt);
        int  w;
        int  c;
        int  sent;
        bit  first;
        predict(abortAt < 0);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.q_valid = 1'b1;
        bus.q_base  = 2'(qB[0]);
        bus.q_last  = (qn == 1);
        bus.arr_vmax = W'(SENT);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checkOutput("clear_q_ready", bus.q_ready, 0);
        checkOutput("clear_arr_clear", bus.arr_clear, 1);
        for (int i = 0; i < qn; i++) begin
            if (i > 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.q_valid = 1'b0;
                    @(negedge clk);
                end
                bus.q_valid = 1'b1;
                bus.q_base  = 2'(qB[i]);
                bus.q_last  = (i == qn - 1);
            end
            w = 0;
            while (!bus.q_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!bus.q_ready) begin
                checkOutput("q_ready_wait", bus.q_ready, 1);
                bus.q_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.q_valid = 1'b0;
        bus.q_last  = 1'b0;
        checkOutput("stream_r_ready", bus.r_ready, 1);
        c = -1;
        first = 1'b0;
        sent = 0;
        for (int e = 0; e < rV.size(); e++) begin
            if (abortAt == e) begin
                bus.r_valid = 1'b0;
                bus.r_last  = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                #2;
                checkOutput("rst_busy", bus.busy, 0);
                checkOutput("rst_arr_clear", bus.arr_clear, 1);
                checkOutput("rst_done", bus.done, 0);
                checkOutput("rst_err_q_overflow", bus.err_q_overflow, 0);
                checkOutput("rst_ref_len", bus.ref_len, 0);
                checkOutput("rst_mask", bus.arr_pe_mask, 0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                checkOutput("post_rst_arr_clear", bus.arr_clear, 0);
                checkOutput("post_rst_busy", bus.busy, 0);
                return;
            end
            if (first) c++;
            if (rV[e] != 0 && !first) begin
                first = 1'b1;
                c = 0;
            end
            bus.r_valid = (rV[e] != 0);
            bus.r_base  = 2'(rB[e]);
            bus.r_last  = (rV[e] != 0) && (sent == rn - 1);
            if (rV[e] != 0) sent++;
            if (c >= 1) bus.arr_vmax = W'(vm[c-1]);
            else        bus.arr_vmax = W'(SENT);
            @(negedge clk);
        end
        for (int d = 0; d <= NP; d++) begin
            c++;
            bus.r_valid  = 1'b0;
            bus.r_last   = 1'b0;
            bus.r_base   = 2'b00;
            bus.arr_vmax = W'(vm[c-1]);
            bus.start    = (d == 1);
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.arr_vmax = W'(SENT);
        @(negedge clk);
        w = 0;
        while (jobsDone < jobsExp && w < 4) begin
            @(negedge clk);
            w++;
        end
        checkOutput("done_seen", jobsDone, jobsExp);
        checkOutput("strobes_left", strbQ.size(), 0);
    endtask

    // Monitor: samples settled outputs mid-cycle and pops the scoreboards.
    always begin
        strb_t sb;
        res_t  r;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (bus.arr_store_s != '0) begin
                if (strbQ.size() == 0) begin
                    checkOutput("unexpected_strobe", bus.arr_store_s, 0);
                end else begin
                    sb = strbQ.pop_front();
                    checkOutput("store_s", bus.arr_store_s, sb.st);
                    checkOutput("arr_s", bus.arr_s, sb.s);
                end
            end
            if (bus.r_valid && bus.r_ready && bus.r_last) rlastCyc = cyc;
            if (bus.done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", bus.done, 0);
                end else begin
                    r = expQ.pop_front();
                    checkOutput("best_score", bus.best_score, r.best);
                    checkOutput("best_cyc", bus.best_cyc, r.cyc);
                    checkOutput("ref_len", bus.ref_len, r.rlen);
                    checkOutput("err_q_overflow", bus.err_q_overflow, r.ovf);
                    checkOutput("err_underrun", bus.err_underrun, r.und);
                    checkOutput("pe_mask", bus.arr_pe_mask, r.mask);
                    checkOutput("done_latency", cyc - rlastCyc - 1, NP + 1);
                    checkOutput("busy_at_done", bus.busy, 1);
                end
                jobsDone++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start    = 1'b0;
        bus.q_valid  = 1'b0;
        bus.q_base   = 2'b00;
        bus.q_last   = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_base   = 2'b00;
        bus.r_last   = 1'b0;
        bus.arr_vmax = W'(SENT);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_arr_clear", bus.arr_clear, 1);
        checkOutput("reset_q_ready", bus.q_ready, 0);
        checkOutput("reset_r_ready", bus.r_ready, 0);
        checkOutput("reset_best_score", bus.best_score, 0);
        checkOutput("reset_mask", bus.arr_pe_mask, 0);
        checkOutput("reset_store_s", bus.arr_store_s, 0);
        @(negedge clk);
        rst = 1'b0;

        buildJob(4, 4, 0, 0, 1'b0, 1'b0);
        qB = '{0, 1, 2, 3};
        vm = '{0, 2, 4, 6, 8, 6, 4, 2};
        applyStimulus(-1);

        buildJob(2, 5, 1, 0, 1'b0, 1'b0);
        vm = '{0, 5, 3, 5, 7, 7, 1, -2, 0};
        applyStimulus(-1);

        buildJob(6, 3, 0, 0, 1'b0, 1'b0);
        applyStimulus(-1);

        buildJob(3, 10, 0, 3, 1'b0, 1'b0);
        applyStimulus(-1);

        buildJob(1, 1, 0, 0, 1'b0, 1'b0);
        applyStimulus(-1);

        buildJob(3, 4, 2, 0, 1'b0, 1'b1);
        applyStimulus(-1);

        buildJob(6, 8, 0, 0, 1'b0, 1'b0);
        applyStimulus(3);

        buildJob(4, 6, 0, 0, 1'b0, 1'b0);
        applyStimulus(-1);

        for (int j = 0; j < 20; j++) begin
            buildJob(int'($urandom_range(1, 6)), int'($urandom_range(1, 12)),
                     int'($urandom_range(0, 2)), 0, 1'b1, ($urandom_range(0, 5) == 0));
            applyStimulus(-1);
        end

        checkOutput("pending_results", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
